// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if: serial link side and parallel channel side of the TDM receiver.
//   master : link source / channel consumer (drives din, din_valid, frame_sync)
//   slave  : tdm_demux8 (drives ch, ch_valid, slot, locked, sync_err)
//   din        serial data bit for the current slot
//   din_valid  din and frame_sync qualify a beat only when 1
//   frame_sync with din_valid: this beat is slot 0
//   ch         last complete frame; ch[k] = bit received in slot k
//   ch_valid   one-cycle pulse, ch holds a new frame
//   slot       slot index the next accepted beat will occupy
//   locked     1 while frame-aligned
//   sync_err   one-cycle pulse, frame_sync arrived at a nonzero slot
interface tdm_demux8_if #(
    parameter int unsigned NCH = 8,
    parameter int unsigned SW  = 3
);
    logic           din;
    logic           din_valid;
    logic           frame_sync;
    logic [NCH-1:0] ch;
    logic           ch_valid;
    logic [SW-1:0]  slot;
    logic           locked;
    logic           sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch, ch_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch, ch_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of the 8:1 bit-level time-division link.
// Each accepted beat (din_valid=1) steers din into the slot given by an internal
// counter; when the last slot of a frame arrives the whole frame is published on
// ch with a one-cycle ch_valid pulse. frame_sync aligns the counter to slot 0.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   tdm_demux8_if.slave (serial input, parallel channel output, status)
module tdm_demux8 #(
    parameter int unsigned NCH = 8,
    parameter int unsigned SW  = 3
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux8_if.slave  bus
);

    typedef enum logic [0:0] {StHunt, StRun} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [NCH-1:0] buf_q, buf_d;
    logic [NCH-1:0] ch_q, ch_d;
    logic           ch_valid_q, ch_valid_d;
    logic           sync_err_q, sync_err_d;

    localparam logic [SW-1:0] LastSlot = SW'(NCH - 1);
    localparam logic [SW-1:0] SlotOne  = SW'(1);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        buf_d      = buf_q;
        ch_d       = ch_q;
        ch_valid_d = 1'b0;
        sync_err_d = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                StHunt: begin
                    // Unsynced beats are discarded until the first frame_sync.
                    if (bus.frame_sync) begin
                        buf_d[0] = bus.din;
                        slot_d   = SlotOne;
                        state_d  = StRun;
                    end
                end
                StRun: begin
                    if (bus.frame_sync && (slot_q != '0)) begin
                        // Misaligned sync: drop the partial frame, restart at slot 0.
                        sync_err_d = 1'b1;
                        buf_d[0]   = bus.din;
                        slot_d     = SlotOne;
                    end else begin
                        buf_d[slot_q] = bus.din;
                        slot_d        = slot_q + SlotOne;  // wraps NCH-1 -> 0
                        if (slot_q == LastSlot) begin
                            ch_d       = buf_d;
                            ch_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHunt;
            slot_q     <= '0;
            buf_q      <= '0;
            ch_q       <= '0;
            ch_valid_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            buf_q      <= buf_d;
            ch_q       <= ch_d;
            ch_valid_q <= ch_valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign bus.ch       = ch_q;
    assign bus.ch_valid = ch_valid_q;
    assign bus.slot     = slot_q;
    assign bus.locked   = (state_q == StRun);
    assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed scenarios plus randomized traffic for tdm_demux8,
// compared every cycle against a frame-collecting reference model.
module tb_tdm_demux8;

    localparam int unsigned NCH = 8;
    localparam int unsigned SW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tdm_demux8_if #(.NCH(NCH), .SW(SW)) bus ();

    tdm_demux8 #(.NCH(NCH), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference model: bits of the frame being collected, in arrival order.
    bit             m_locked;
    bit             m_frame[$];
    bit [NCH-1:0]   m_ch;
    bit             m_ch_valid;
    bit             m_sync_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit fs, input bit d);
        m_ch_valid = 1'b0;
        m_sync_err = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_frame.delete();
            m_ch = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_locked = 1'b1;
                    m_frame.delete();
                    m_frame.push_back(d);
                end
            end else if (fs && m_frame.size() != 0) begin
                m_sync_err = 1'b1;
                m_frame.delete();
                m_frame.push_back(d);
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == NCH) begin
                    for (int k = 0; k < NCH; k++) m_ch[k] = m_frame[k];
                    m_ch_valid = 1'b1;
                    m_frame.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ch", 32'(bus.ch), 32'(m_ch));
        chk("ch_valid", 32'(bus.ch_valid), 32'(m_ch_valid));
        chk("slot", 32'(bus.slot), 32'(m_frame.size()));
        chk("locked", 32'(bus.locked), 32'(m_locked));
        chk("sync_err", 32'(bus.sync_err), 32'(m_sync_err));
        chk("exclusive", 32'(bus.ch_valid & bus.sync_err), 32'd0);
    endtask

    // Drive one cycle, then compare 1 time unit after the edge.
    task automatic step(input bit r, input bit v, input bit fs, input bit d);
        rst            = r;
        bus.din_valid  = v;
        bus.frame_sync = fs;
        bus.din        = d;
        @(posedge clk);
        model_edge(r, v, fs, d);
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [NCH-1:0] bits, input bit sync);
        for (int k = 0; k < NCH; k++) step(1'b0, 1'b1, sync && (k == 0), bits[k]);
    endtask

    initial begin
        logic [NCH-1:0] v;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        m_locked = 1'b0;
        m_ch = '0;
        m_ch_valid = 1'b0;
        m_sync_err = 1'b0;
        @(negedge clk);

        // 1: basic frame
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_ch", 32'(bus.ch), 32'd0);
        chk("reset_locked", 32'(bus.locked), 32'd0);
        send_frame(8'b0100_1101, 1'b1);
        chk("t1_ch", 32'(bus.ch), 32'h4D);
        chk("t1_valid", 32'(bus.ch_valid), 32'd1);
        chk("t1_locked", 32'(bus.locked), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_pulse", 32'(bus.ch_valid), 32'd0);

        // 2: unsynced beats in HUNT are discarded
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom));
        chk("t2_slot", 32'(bus.slot), 32'd0);
        chk("t2_locked", 32'(bus.locked), 32'd0);
        v = NCH'($urandom);
        send_frame(v, 1'b1);
        chk("t2_ch", 32'(bus.ch), 32'(v));

        // 3: misaligned sync
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_sync_err", 32'(bus.sync_err), 32'd1);
        chk("t3_no_valid", 32'(bus.ch_valid), 32'd0);
        chk("t3_slot", 32'(bus.slot), 32'd1);
        for (int i = 1; i < NCH; i++) step(1'b0, 1'b1, 1'b0, 1'(i & 1));
        chk("t3_valid", 32'(bus.ch_valid), 32'd1);
        chk("t3_ch", 32'(bus.ch), 32'hAA);

        // 4: gaps between beats, ignored inputs randomized
        v = 8'hA5;
        for (int k = 0; k < NCH; k++) begin
            step(1'b0, 1'b1, k == 0, v[k]);
            if (k != NCH - 1) begin
                step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
                chk("t4_frozen", 32'(bus.slot), 32'(k + 1));
            end
        end
        chk("t4_ch", 32'(bus.ch), 32'hA5);

        // 5: back-to-back frames, sync on the first only
        send_frame(8'hFF, 1'b1);
        chk("t5_ch_ff", 32'(bus.ch), 32'hFF);
        send_frame(8'h00, 1'b0);
        chk("t5_valid2", 32'(bus.ch_valid), 32'd1);
        chk("t5_ch_00", 32'(bus.ch), 32'h00);

        // 6: reset mid-frame
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i == 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t6_slot", 32'(bus.slot), 32'd0);
        chk("t6_locked", 32'(bus.locked), 32'd0);
        chk("t6_ch", 32'(bus.ch), 32'd0);
        v = NCH'($urandom);
        send_frame(v, 1'b1);
        chk("t6_ch_new", 32'(bus.ch), 32'(v));

        // Randomized traffic: gaps, stray syncs, occasional reset
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
